// File: rtl/shake256_pad_pkg.sv
// Shared constants and types for the SHAKE256 final-block padder.
package shake_pkg;

    localparam int RATE           = 1088;
    localparam int LEN_W          = 11;
    localparam int SUFFIX_W       = 4;
    localparam logic [SUFFIX_W-1:0] SHAKE_SUFFIX = 4'b1111;
    localparam int SINGLE_MAX_LEN = RATE - 6;

    typedef logic [RATE-1:0] rate_block_t;

endpackage

// File: rtl/shake256_pad_mask_gen.sv
// Length-driven mask generator: thermometer keep-mask over the rate block and
// the five suffix/first-pad markers at stream positions L..L+4 over two blocks.
// Stream position p maps to bit (width-1-p), so right shifts move toward later positions.
module pad_mask_gen
    import shake_pkg::*;
#(
    parameter int RATE  = shake_pkg::RATE,
    parameter int LEN_W = shake_pkg::LEN_W
) (
    input  logic [LEN_W-1:0]  len,
    output logic [RATE-1:0]   keep_mask,
    output logic [2*RATE-1:0] marker_mask
);

    localparam int MARK_W = SUFFIX_W + 1;
    localparam logic [RATE-1:0]   ALL_ONES  = '1;
    localparam logic [2*RATE-1:0] MARK_BASE = {SHAKE_SUFFIX, 1'b1, {(2*RATE-MARK_W){1'b0}}};

    // Shift the constant patterns down the stream by the (already clamped) length.
    always_comb begin
        keep_mask   = ~(ALL_ONES >> len);
        marker_mask = MARK_BASE >> len;
    end

endmodule

// File: rtl/shake256_pad.sv
// Registered SHAKE256 final-block padder: masks the partial block, appends the
// 1111 domain suffix and pad10*1, and emits one or two padded rate blocks.
module shake256_pad
    import shake_pkg::*;
#(
    parameter int RATE  = shake_pkg::RATE,
    parameter int LEN_W = shake_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [RATE-1:0]   data_in,
    input  logic [LEN_W-1:0]  data_length,
    output logic [RATE-1:0]   data_out,
    output logic [RATE-1:0]   data_next,
    output logic              need_next,
    output logic              out_valid
);

    localparam logic [LEN_W-1:0] RATE_LEN   = LEN_W'(RATE);
    localparam logic [LEN_W-1:0] SINGLE_LEN = LEN_W'(RATE - 6);

    logic [LEN_W-1:0]  len_c;
    logic [RATE-1:0]   keep_mask;
    logic [2*RATE-1:0] marker_mask;
    logic [2*RATE-1:0] stream;

    logic [RATE-1:0]   data_out_d,  data_out_q;
    logic [RATE-1:0]   data_next_d, data_next_q;
    logic              need_next_d, need_next_q;
    logic              out_valid_d, out_valid_q;

    // Lengths above the rate saturate to a full block.
    always_comb begin
        len_c = (data_length > RATE_LEN) ? RATE_LEN : data_length;
    end

    pad_mask_gen #(
        .RATE  (RATE),
        .LEN_W (LEN_W)
    ) u_mask_gen (
        .len         (len_c),
        .keep_mask   (keep_mask),
        .marker_mask (marker_mask)
    );

    // Assemble the two-block stream and select the next output values.
    always_comb begin
        stream = {data_in & keep_mask, {RATE{1'b0}}} | marker_mask;
        if (len_c <= SINGLE_LEN) begin
            stream[RATE] = 1'b1;
        end else begin
            stream[0] = 1'b1;
        end

        data_out_d  = data_out_q;
        data_next_d = data_next_q;
        need_next_d = need_next_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            data_out_d  = stream[2*RATE-1:RATE];
            data_next_d = stream[RATE-1:0];
            need_next_d = (len_c > SINGLE_LEN);
        end
    end

    // Output registers; async reset drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            data_next_q <= '0;
            need_next_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            data_next_q <= data_next_d;
            need_next_q <= need_next_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign data_next = data_next_q;
    assign need_next = need_next_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shake256_pad.sv
// Self-checking bench for shake256_pad: directed boundary cases plus random
// vectors against a position-by-position stream model.
module tb_shake256_pad;
    import shake_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    rate_block_t       data_in;
    logic [LEN_W-1:0]  data_length;
    rate_block_t       data_out;
    rate_block_t       data_next;
    logic              need_next;
    logic              out_valid;

    int unsigned vectors;
    int unsigned miscompares;

    shake256_pad #(
        .RATE  (RATE),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .data_in     (data_in),
        .data_length (data_length),
        .data_out    (data_out),
        .data_next   (data_next),
        .need_next   (need_next),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_blk(input string tag, input rate_block_t obs, input rate_block_t exp);
        int first_diff;
        vectors++;
        first_diff = -1;
        for (int i = RATE - 1; i >= 0; i--) begin
            if (first_diff < 0 && obs[i] !== exp[i]) first_diff = i;
        end
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: first differing bit %0d, observed hi=%h lo=%h, expected hi=%h lo=%h",
                   tag, first_diff, obs[RATE-1 -: 64], obs[63:0], exp[RATE-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: build the stream position by position from the padding rules.
    task automatic model(input rate_block_t d, input int unsigned len,
                         output rate_block_t eo, output rate_block_t en, output logic need);
        bit s [0:2*RATE-1];
        int unsigned l;
        l = (len > RATE) ? RATE : len;
        for (int unsigned p = 0; p < 2 * RATE; p++) s[p] = 1'b0;
        for (int unsigned p = 0; p < l; p++) s[p] = d[RATE-1-p];
        for (int unsigned k = 0; k < 5; k++) s[l+k] = 1'b1;
        if (l + 6 <= RATE) s[RATE-1] = 1'b1;
        else               s[2*RATE-1] = 1'b1;
        for (int unsigned p = 0; p < RATE; p++) begin
            eo[RATE-1-p] = s[p];
            en[RATE-1-p] = s[RATE+p];
        end
        need = (l + 6 > RATE);
    endtask

    task automatic check_result(input string tag, input rate_block_t d, input int unsigned len);
        rate_block_t eo, en;
        logic need;
        model(d, len, eo, en, need);
        chk_bit({tag, " out_valid"}, out_valid, 1'b1);
        chk_blk({tag, " data_out"}, data_out, eo);
        chk_blk({tag, " data_next"}, data_next, en);
        chk_bit({tag, " need_next"}, need_next, need);
    endtask

    task automatic run_one(input string tag, input rate_block_t d, input int unsigned len);
        @(negedge clk);
        data_in     = d;
        data_length = LEN_W'(len);
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_result(tag, d, len);
    endtask

    function automatic rate_block_t rand_block();
        rate_block_t r;
        for (int i = 0; i < RATE / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        rate_block_t ones, zeros, d, d2, last_o, last_n;
        rate_block_t k_l5, k_f8_01, k_one;
        int unsigned len, len2;

        vectors     = 0;
        miscompares = 0;
        ones        = '1;
        zeros       = '0;
        k_l5        = {12'h9FC, 1072'b0, 4'h1};
        k_f8_01     = {8'hF8, 1072'b0, 8'h01};
        k_one       = {1087'b0, 1'b1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        data_in     = '0;
        data_length = '0;
        #12;
        chk_blk("reset data_out", data_out, zeros);
        chk_blk("reset data_next", data_next, zeros);
        chk_bit("reset need_next", need_next, 1'b0);
        chk_bit("reset out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with literal expectations.
        d = '0;
        d[RATE-1 -: 5] = 5'b10011;
        run_one("L5", d, 5);
        chk_blk("L5 literal", data_out, k_l5);

        run_one("L0", ones, 0);
        chk_blk("L0 literal", data_out, k_f8_01);

        run_one("L1082", ones, 1082);
        chk_blk("L1082 literal", data_out, ones);
        chk_blk("L1082 next literal", data_next, zeros);

        run_one("L1083", ones, 1083);
        chk_blk("L1083 literal", data_out, ones);
        chk_blk("L1083 next literal", data_next, k_one);

        run_one("L1088", ones, 1088);
        chk_blk("L1088 next literal", data_next, k_f8_01);

        run_one("L2047", ones, 2047);
        chk_blk("L2047 literal", data_out, ones);
        chk_blk("L2047 next literal", data_next, k_f8_01);

        // Outputs hold while in_valid is low.
        last_o = data_out;
        last_n = data_next;
        @(posedge clk);
        #1;
        chk_bit("idle out_valid", out_valid, 1'b0);
        chk_blk("idle hold data_out", data_out, last_o);
        chk_blk("idle hold data_next", data_next, last_n);
        chk_bit("idle hold need_next", need_next, 1'b1);

        // Random vectors, biased toward the block boundary.
        for (int i = 0; i < 40; i++) begin
            d = rand_block();
            case (i % 3)
                0:       len = $urandom_range(0, 2047);
                1:       len = $urandom_range(1076, 1094);
                default: len = $urandom_range(0, 1088);
            endcase
            run_one($sformatf("rand%0d L%0d", i, len), d, len);
        end

        // Back-to-back: L=5 then L=1083 on consecutive cycles.
        d  = rand_block();
        d2 = rand_block();
        @(negedge clk);
        data_in     = d;
        data_length = LEN_W'(5);
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        check_result("b2b first L5", d, 5);
        data_in     = d2;
        data_length = LEN_W'(1083);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_result("b2b second L1083", d2, 1083);

        // Async reset mid-stream: in-flight result is dropped.
        @(negedge clk);
        data_in     = ones;
        data_length = LEN_W'(1088);
        in_valid    = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_blk("async rst data_out", data_out, zeros);
        chk_blk("async rst data_next", data_next, zeros);
        chk_bit("async rst need_next", need_next, 1'b0);
        chk_bit("async rst out_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("post rst out_valid", out_valid, 1'b0);
        chk_blk("post rst data_out", data_out, zeros);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shake256_pad.md
Name:
shake256_pad

Overview:
- Registered SHAKE256 final-block padder for the sponge absorb path.
- Takes the last, partial rate block of a message (up to 1088 bits, MSB-first), masks out unused bits, appends the SHAKE domain suffix 1111, and applies Keccak pad10*1.
- Produces one padded block, or two when the padding spills past the rate boundary.
- Sits between the message buffer and the absorb/permutation controller.

Parameters:
- RATE, 1088, sponge rate in bits (SHAKE256).
- LEN_W, 11, width of the length field; must satisfy 2^LEN_W > RATE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies data_in/data_length for one cycle.
- data_in  in  RATE  message bits, MSB-first; position p (0..RATE-1) maps to bit RATE-1-p.
- data_length  in  LEN_W  number of valid message bits, 0..RATE.
- data_out  out  RATE  first padded block.
- data_next  out  RATE  second padded block; all-zero when unused.
- need_next  out  1  data_next is a required extra block.
- out_valid  out  1  outputs hold a new result.

Behaviour:
- Reset (rst_n low, async): data_out, data_next = 0; need_next = 0; out_valid = 0.
- Latency: 1 cycle. in_valid sampled at edge N gives the result at edge N+1 with out_valid high for exactly one cycle.
- When in_valid is low, out_valid deasserts and data_out, data_next and need_next hold their last values.
- Back-to-back in_valid is supported: one result per cycle, no backpressure.
- Clamp: L = min(data_length, RATE). Values above 1088 are treated as 1088.
- Mask: positions p >= L of data_in are forced to 0. Caller garbage is ignored.
- Construct a 2*RATE-bit stream S, positions 0..2175:
  - S[0..L-1] = message bits.
  - S[L..L+3] = 1111 (domain suffix).
  - S[L+4] = 1 (first pad bit).
  - Final pad bit = 1 at S[RATE-1] if L <= RATE-6; otherwise at S[2*RATE-1].
  - All other positions = 0.
- Single-block case (L <= 1082): data_out = S[0..RATE-1]; data_next = 0; need_next = 0.
- Two-block case (1083 <= L <= 1088): data_out = S[0..RATE-1]; data_next = S[RATE..2*RATE-1]; need_next = 1.
  - L = 1083: first pad bit lands on the last position of block 0; block 1 holds only the final bit.
- The first and final pad bits never coincide; pad10*1 is always at least 2 bits.
- Bit ordering is MSB-first stream order. Any byte/lane endianness conversion to Keccak state order is the consumer's job.
- Datapath is purely combinational from the input registers' D side. Only the outputs are flopped. Reset mid-operation drops the in-flight result.

Decomposition:
- Package shake_pkg:
  - RATE = 1088, LEN_W = 11.
  - SHAKE_SUFFIX = 4'b1111, SUFFIX_W = 4.
  - SINGLE_MAX_LEN = RATE-6 = 1082.
  - typedef rate_block_t = logic [RATE-1:0].
- One natural sub-module: pad_mask_gen. It produces the RATE-bit thermometer keep-mask for L and the one-hot markers at L..L+4 over 2*RATE bits.

Test Plan:
- L=5, data_in top bits 10011, rest 0, in_valid one cycle -> next cycle out_valid=1; data_out = 0x9FC, then 268 zero hex digits, then 0x1; data_next = 0; need_next = 0.
- L=0, data_in all ones -> data_out = 0xF8, then 268 zero hex digits, then 0x01 (input fully masked); need_next = 0.
- L=1082, data_in all ones -> data_out all ones; need_next = 0; data_next = 0.
- L=1083, data_in all ones -> data_out all ones; data_next = 0...01; need_next = 1.
- L=1088 and L=2047, data_in all ones -> both give data_out all ones; data_next = 0xF8, then zeros, then 0x01 (data_next bit 0 = 1); need_next = 1.
- Reset asserted asynchronously mid-stream after a valid input -> outputs 0 immediately, no out_valid after release. Back-to-back inputs L=5 then L=1083 -> two consecutive correct results.
